pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//   Central stall/flush sequencer for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
//   Detects load-use hazards on ID source registers and applies branch-redirect flushes.
//   Freezes the pipe during multi-cycle data-memory accesses.
//   Drains and halts the core on a debug halt request; resumes on request.
// PARAMETERS
//   DRAIN_CYC  4   cycles of bubble injection after halt_req before HALTED (stages behind IF)
//   TIMEOUT    255 max consecutive MEM_WAIT cycles before mem_err / forced halt
//   CNT_W      32  width of the stall-cycle performance counter
// PORTS
//   clk          in   1      core clock, rising edge
//   rst_n        in   1      asynchronous reset, active low
//   id_rs1       in   5      rs1 field of instruction in ID
//   id_rs2       in   5      rs2 field of instruction in ID
//   id_rs1_used  in   1      ID instruction reads rs1 (0 for U/J types)
//   id_rs2_used  in   1      ID instruction reads rs2 (R/S/B types only)
//   ex_rd        in   5      destination of instruction in EX
//   ex_mem_read  in   1      EX instruction is a load
//   ex_br_taken  in   1      EX resolved a taken branch/jump (PC redirect this cycle)
//   mem_req      in   1      MEM stage holds a valid load/store
//   mem_ready    in   1      data memory completes access this cycle
//   halt_req     in   1      level request to halt (debug unit)
//   resume       in   1      single-cycle pulse to leave HALTED
//   stall_if     out  1      hold PC
//   stall_id     out  1      hold IF/ID register
//   stall_ex     out  1      hold ID/EX register
//   stall_mem    out  1      hold EX/MEM register
//   flush_id     out  1      clear IF/ID to bubble
//   flush_ex     out  1      clear ID/EX to bubble
//   flush_wb     out  1      clear MEM/WB to bubble
//   halted       out  1      registered; 1 while in HALTED
//   mem_err      out  1      registered one-cycle pulse on memory timeout
//   stall_cnt    out  CNT_W  registered, saturating count of cycles with stall_if=1
// BEHAVIOUR
//   Reset (rst_n=0, async): state=RUN, drain/timeout counters=0, halted=0, mem_err=0,
//     stall_cnt=0; all stall_*/flush_* forced 0 while rst_n low. Reset mid-operation aborts any state.
//   stall_*/flush_* are combinational from state and current inputs (zero-latency, same cycle).
//   halted, mem_err and stall_cnt update on clk.
//   load_use = ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
//   mwait = mem_req & ~mem_ready.
//   Output priority (highest first), per cycle:
//     1 HALTED: all stall_*=1, flushes=0.
//     2 mwait: stall_if/id/ex/mem=1, flush_wb=1, flush_id=flush_ex=0 (branch/load-use deferred).
//     3 ex_br_taken: flush_id=1, flush_ex=1, stall_*=0 (PC loads target; overrides load-use and drain hold).
//     4 load_use: stall_if=1, stall_id=1, flush_ex=1.
//     5 DRAIN (no event above): stall_if=1, flush_id=1.
//     6 otherwise all 0.
//   FSM states: RUN, MEM_WAIT, DRAIN, HALTED.
//     RUN -> MEM_WAIT when mwait.
//     RUN -> DRAIN when halt_req & ~mwait; load drain_cnt=DRAIN_CYC-1.
//     MEM_WAIT: tmo_cnt increments each cycle.
//       On mem_ready: go DRAIN if halt_req, else RUN; tmo_cnt=0.
//       If tmo_cnt==TIMEOUT-1 & ~mem_ready: mem_err pulses next cycle, go HALTED.
//       In HALTED the pending access stays frozen in MEM.
//     DRAIN: drain_cnt decrements on cycles without mwait and is paused during mwait.
//       Timeout rules apply during DRAIN too; tmo_cnt runs while mwait.
//       Exit to HALTED when drain_cnt==0 and ~mwait.
//       halt_req deassert during DRAIN is ignored; the drain completes.
//     HALTED -> RUN on resume & ~halt_req. If halt_req is high, resume is ignored.
//       resume outside HALTED is ignored.
//   stall_cnt: +1 per cycle with stall_if=1; holds at 2^CNT_W-1 (no wrap).
// TESTING
//   1 ID add x3,x1,x2; EX lw x1 -> 1 cycle: stall_if=stall_id=flush_ex=1; next cycle all 0, stall_cnt=1.
//   2 EX lw x0 with ID reading x0 -> no stall.
//     ID rs2==ex_rd with id_rs2_used=0 -> no stall.
//   3 load_use & ex_br_taken same cycle -> flush_id=flush_ex=1, stall_if=0.
//   4 mem_req=1, mem_ready low for 3 cycles -> stall_if..mem=1, flush_wb=1 for exactly 3 cycles.
//     ex_br_taken held high during wait -> flush_id=flush_ex asserted only on the mem_ready cycle.
//   5 halt_req pulse in RUN -> 4 cycles stall_if=flush_id=1, then halted=1 and all stalls=1.
//     resume -> halted=0 next cycle.
//   6 mem_ready held 0 for TIMEOUT cycles -> mem_err 1-cycle pulse, halted=1.
//     Assert rst_n=0 mid-wait -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Handles load-use hazards, branch flushes, memory waits and debug drain/halt.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   id_rs1/2, *_used     ID source registers and whether they are read
//   ex_rd, ex_mem_read   EX destination and load flag
//   ex_br_taken          EX redirects the PC this cycle
//   mem_req, mem_ready   MEM access valid / completing
//   halt_req, resume     debug halt level and resume pulse
//   stall_*, flush_*     combinational pipeline controls
//   halted, mem_err      registered status
//   stall_cnt            saturating count of cycles with stall_if=1
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYC = 4,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             halt_req,
    input  logic             resume,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             flush_wb,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_DRAIN,
        S_HALTED
    } state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             halted_q, halted_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic mwait;
    logic load_use;
    logic tmo_hit;

    assign mwait    = mem_req & ~mem_ready;
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));
    assign tmo_hit  = mwait && (tmo_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            drain_q     <= '0;
            tmo_q       <= '0;
            halted_q    <= 1'b0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            tmo_q       <= tmo_d;
            halted_q    <= halted_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        tmo_d     = tmo_q;
        mem_err_d = 1'b0;
        // Counts consecutive wait cycles, including the first one seen in RUN.
        if (state_q != S_HALTED) begin
            tmo_d = mwait ? tmo_q + 1'b1 : '0;
        end
        unique case (state_q)
            S_RUN: begin
                if (mwait) begin
                    state_d = S_MEM_WAIT;
                end else if (halt_req) begin
                    state_d = S_DRAIN;
                    drain_d = DW'(DRAIN_CYC - 1);
                end
            end
            S_MEM_WAIT: begin
                if (!mwait) begin
                    state_d = halt_req ? S_DRAIN : S_RUN;
                    drain_d = DW'(DRAIN_CYC - 1);
                end
            end
            S_DRAIN: begin
                if (!mwait) begin
                    if (drain_q == '0) begin
                        state_d = S_HALTED;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
            end
            S_HALTED: begin
                if (resume && !halt_req) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
        if (state_q != S_HALTED && tmo_hit) begin
            state_d   = S_HALTED;
            tmo_d     = '0;
            drain_d   = '0;
            mem_err_d = 1'b1;
        end
        halted_d = (state_d == S_HALTED);
    end

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        flush_wb  = 1'b0;
        if (!rst_n) begin
            stall_if = 1'b0;
        end else if (state_q == S_HALTED) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
        end else if (mwait) begin
            // Bubble into WB while MEM is frozen; redirects wait.
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            flush_wb  = 1'b1;
        end else if (ex_br_taken) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end else if (state_q == S_DRAIN) begin
            stall_if = 1'b1;
            flush_id = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_if && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign halted    = halted_q;
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a cycle-level reference model.
// Directed sequences cover load-use, halt drain, timeout and mid-wait reset.
module tb_pipe_hazard_ctrl;

    localparam int DRAIN_CYC = 4;
    localparam int TIMEOUT   = 255;
    localparam int CNT_W     = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_rs1_used, id_rs2_used;
    logic ex_mem_read, ex_br_taken;
    logic mem_req, mem_ready, halt_req, resume;
    logic stall_if, stall_id, stall_ex, stall_mem;
    logic flush_id, flush_ex, flush_wb;
    logic halted, mem_err;
    logic [CNT_W-1:0] stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    bit m_halt;
    int m_drain_left;
    int m_wait_run;
    bit m_err;
    int m_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .DRAIN_CYC(DRAIN_CYC),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used),
        .ex_rd      (ex_rd),
        .ex_mem_read(ex_mem_read),
        .ex_br_taken(ex_br_taken),
        .mem_req    (mem_req),
        .mem_ready  (mem_ready),
        .halt_req   (halt_req),
        .resume     (resume),
        .stall_if   (stall_if),
        .stall_id   (stall_id),
        .stall_ex   (stall_ex),
        .stall_mem  (stall_mem),
        .flush_id   (flush_id),
        .flush_ex   (flush_ex),
        .flush_wb   (flush_wb),
        .halted     (halted),
        .mem_err    (mem_err),
        .stall_cnt  (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_halt       = 1'b0;
        m_drain_left = 0;
        m_wait_run   = 0;
        m_err        = 1'b0;
        m_cnt        = 0;
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_rs1_used = 0; id_rs2_used = 0;
        ex_mem_read = 0; ex_br_taken = 0;
        mem_req = 0; mem_ready = 0;
        halt_req = 0; resume = 0;
    endtask

    function automatic logic [31:0] comb_outs();
        return 32'({stall_if, stall_id, stall_ex, stall_mem,
                    flush_id, flush_ex, flush_wb});
    endfunction

    // One clock: check combinational outputs for the current inputs,
    // advance the model at the edge, then check registered outputs.
    task automatic cyc();
        bit mw, lu;
        logic [6:0] e;
        mw = mem_req && !mem_ready;
        lu = ex_mem_read && ex_rd != 0 &&
             ((id_rs1_used && id_rs1 == ex_rd) ||
              (id_rs2_used && id_rs2 == ex_rd));
        if (m_halt)               e = 7'b1111000;
        else if (mw)              e = 7'b1111001;
        else if (ex_br_taken)     e = 7'b0000110;
        else if (lu)              e = 7'b1100010;
        else if (m_drain_left > 0) e = 7'b1000100;
        else                      e = 7'b0000000;
        #1;
        chk("ctrl", comb_outs(), 32'(e));
        @(posedge clk);
        if (e[6] && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        m_err = 1'b0;
        if (m_halt) begin
            m_wait_run = 0;
            if (resume && !halt_req) m_halt = 1'b0;
        end else if (mw) begin
            m_wait_run++;
            if (m_wait_run == TIMEOUT) begin
                m_halt = 1'b1;
                m_err = 1'b1;
                m_drain_left = 0;
                m_wait_run = 0;
            end
        end else begin
            m_wait_run = 0;
            if (m_drain_left > 0) begin
                m_drain_left--;
                if (m_drain_left == 0) m_halt = 1'b1;
            end else if (halt_req) begin
                m_drain_left = DRAIN_CYC;
            end
        end
        #1;
        chk("halted", 32'(halted), 32'(m_halt));
        chk("mem_err", 32'(mem_err), 32'(m_err));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        // Hazard-producing inputs must not leak through while in reset.
        id_rs1 = 5'd1; id_rs1_used = 1; ex_rd = 5'd1; ex_mem_read = 1;
        mem_req = 1;
        #3;
        chk("rst_ctrl", comb_outs(), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Load-use: add x3,x1,x2 after lw x1
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_rs1_used = 1; id_rs2_used = 1;
        ex_rd = 5'd1; ex_mem_read = 1;
        cyc();
        idle_inputs();
        cyc();
        chk("lu_cnt", 32'(stall_cnt), 32'd1);

        // x0 destination and unused rs2 never stall
        ex_mem_read = 1; ex_rd = 0; id_rs1_used = 1; id_rs2_used = 1;
        cyc();
        ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 0; id_rs1 = 5'd3;
        cyc();
        // Branch overrides load-use
        id_rs1 = 5'd7; id_rs1_used = 1; ex_br_taken = 1;
        cyc();
        idle_inputs();

        // Three-cycle memory wait with a pending branch
        mem_req = 1; ex_br_taken = 1;
        repeat (3) cyc();
        mem_ready = 1;
        cyc();
        idle_inputs();

        // Halt pulse, drain, halt, resume
        halt_req = 1;
        cyc();
        halt_req = 0;
        repeat (6) cyc();
        chk("halt_seen", 32'(halted), 32'd1);
        resume = 1;
        cyc();
        chk("resumed", 32'(halted), 32'd0);
        resume = 0;
        cyc();

        // Timeout: memory never completes
        do_reset();
        mem_req = 1; mem_ready = 0;
        repeat (TIMEOUT + 3) cyc();
        chk("tmo_halted", 32'(halted), 32'd1);

        // Reset in the middle of a wait
        do_reset();
        mem_req = 1; mem_ready = 0;
        repeat (40) cyc();
        rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", comb_outs(), 32'd0);
        chk("midrst_halted", 32'(halted), 32'd0);
        chk("midrst_cnt", 32'(stall_cnt), 32'd0);
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_rs1_used = 1'($urandom_range(0, 1));
            id_rs2_used = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_br_taken = ($urandom_range(0, 4) == 0);
            mem_req     = ($urandom_range(0, 2) == 0);
            mem_ready   = 1'($urandom_range(0, 1));
            halt_req    = ($urandom_range(0, 24) == 0);
            resume      = ($urandom_range(0, 3) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
